// File: rtl/lvds_panel_sequencer.sv
// LVDS panel power sequencer: orders VDD, LVDS and backlight enables on power-up/down
// and holds the panel in WAIT_LOCK until enough consecutive frames carry active video.
module lvds_panel_sequencer #(
    parameter int T_VDD_TO_LVDS = 500000,
    parameter int T_LVDS_TO_BL  = 2500000,
    parameter int T_BL_TO_LVDS  = 2500000,
    parameter int T_LVDS_TO_VDD = 500000,
    parameter int T_VDD_OFF_MIN = 12500000,
    parameter int T_FRAME_MAX   = 1000000,
    parameter int LOCK_FRAMES   = 3
) (
    input  logic       pixelClock,
    input  logic       resetN,
    input  logic       panelOnReq,
    input  logic       vsync,
    input  logic       de,
    output logic       panelVddEn,
    output logic       lvdsEnable,
    output logic       backlightEn,
    output logic       panelReady,
    output logic       syncLost,
    output logic [2:0] seqState
);
    typedef enum logic [2:0] {
        OFF       = 3'd0,
        VDD_UP    = 3'd1,
        LVDS_UP   = 3'd2,
        WAIT_LOCK = 3'd3,
        ON        = 3'd4,
        BL_DOWN   = 3'd5,
        LVDS_DOWN = 3'd6,
        VDD_COOL  = 3'd7
    } seqState_e;

    localparam int MAX_A    = (T_VDD_TO_LVDS > T_LVDS_TO_BL) ? T_VDD_TO_LVDS : T_LVDS_TO_BL;
    localparam int MAX_B    = (T_BL_TO_LVDS > T_LVDS_TO_VDD) ? T_BL_TO_LVDS : T_LVDS_TO_VDD;
    localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int T_MAX    = (MAX_C > T_VDD_OFF_MIN) ? MAX_C : T_VDD_OFF_MIN;
    localparam int TW       = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);
    localparam int WD_LIMIT = (T_FRAME_MAX < 1) ? 1 : T_FRAME_MAX;
    localparam int WW       = $clog2(WD_LIMIT + 1);

    // Dwell of N cycles: load N-1, leave the state on the cycle the timer reads zero.
    function automatic logic [TW-1:0] reloadFor(input int n);
        return (n < 1) ? '0 : TW'(n - 1);
    endfunction

    seqState_e     state, stateNext;
    logic [TW-1:0] timer, timerNext;
    logic [WW-1:0] wdog;
    logic [3:0]    frameCnt, frameCntNext;
    logic          vsyncPrev, deSeen;
    logic          vsyncEdge, expired, watching, timeout, frameValid, lockDone;

    assign vsyncEdge  = vsync & ~vsyncPrev;
    assign expired    = (timer == '0);
    assign watching   = (state == WAIT_LOCK) || (state == ON);
    assign timeout    = watching && !vsyncEdge && (wdog == WW'(WD_LIMIT - 1));
    assign frameValid = vsyncEdge && deSeen;
    assign lockDone   = (state == WAIT_LOCK) && frameValid && (frameCnt == 4'(LOCK_FRAMES - 1));
    assign seqState   = state;

    always_comb begin
        stateNext = state;
        case (state)
            OFF:       if (panelOnReq) stateNext = VDD_UP;
            VDD_UP:    if (!panelOnReq) stateNext = VDD_COOL;
                       else if (expired) stateNext = LVDS_UP;
            LVDS_UP:   if (!panelOnReq) stateNext = LVDS_DOWN;
                       else if (expired) stateNext = WAIT_LOCK;
            WAIT_LOCK: if (!panelOnReq) stateNext = LVDS_DOWN;
                       else if (lockDone) stateNext = ON;
            ON:        if (!panelOnReq || timeout) stateNext = BL_DOWN;
            BL_DOWN:   if (expired) stateNext = panelOnReq ? WAIT_LOCK : LVDS_DOWN;
            LVDS_DOWN: if (expired) stateNext = VDD_COOL;
            VDD_COOL:  if (expired) stateNext = OFF;
            default:   stateNext = OFF;
        endcase
    end

    always_comb begin
        timerNext = '0;
        if (stateNext != state) begin
            case (stateNext)
                VDD_UP:    timerNext = reloadFor(T_VDD_TO_LVDS);
                LVDS_UP:   timerNext = reloadFor(T_LVDS_TO_BL);
                BL_DOWN:   timerNext = reloadFor(T_BL_TO_LVDS);
                LVDS_DOWN: timerNext = reloadFor(T_LVDS_TO_VDD);
                VDD_COOL:  timerNext = reloadFor(T_VDD_OFF_MIN);
                default:   timerNext = '0;
            endcase
        end else if (!expired) begin
            timerNext = timer - TW'(1);
        end
    end

    // Lock progress only survives while staying in WAIT_LOCK without a watchdog hit.
    always_comb begin
        frameCntNext = '0;
        if (state == WAIT_LOCK && stateNext == WAIT_LOCK && !timeout) begin
            if (vsyncEdge) frameCntNext = frameValid ? frameCnt + 4'd1 : 4'd0;
            else           frameCntNext = frameCnt;
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            state       <= OFF;
            timer       <= '0;
            wdog        <= '0;
            frameCnt    <= '0;
            vsyncPrev   <= 1'b0;
            deSeen      <= 1'b0;
            syncLost    <= 1'b0;
            panelVddEn  <= 1'b0;
            lvdsEnable  <= 1'b0;
            backlightEn <= 1'b0;
            panelReady  <= 1'b0;
        end else begin
            state     <= stateNext;
            timer     <= timerNext;
            frameCnt  <= frameCntNext;
            vsyncPrev <= vsync;
            deSeen    <= vsyncEdge ? 1'b0 : (deSeen | de);
            if ((stateNext == WAIT_LOCK && state != WAIT_LOCK) || !watching || vsyncEdge || timeout)
                wdog <= '0;
            else
                wdog <= wdog + WW'(1);
            if (timeout)
                syncLost <= 1'b1;
            else if ((stateNext == ON && state != ON) || stateNext == OFF)
                syncLost <= 1'b0;
            panelVddEn  <= (stateNext != OFF) && (stateNext != VDD_COOL);
            lvdsEnable  <= (stateNext == LVDS_UP) || (stateNext == WAIT_LOCK) ||
                           (stateNext == ON) || (stateNext == BL_DOWN);
            backlightEn <= (stateNext == ON);
            panelReady  <= (stateNext == ON);
        end
    end
endmodule

// File: tb/tb_lvds_panel_sequencer.sv
// Bench for lvds_panel_sequencer: timestamp-based reference model checked every cycle,
// plus directed power-up, sync-loss, invalid-frame, power-down, abort and reset scenarios.
module tb_lvds_panel_sequencer;
    localparam int TV = 10, TL = 20, TB = 5, TD = 8, TC = 50, TF = 100, LF = 2;

    logic       pixelClock = 1'b0;
    logic       resetN = 1'b0;
    logic       panelOnReq = 1'b0;
    logic       vsync, de;
    logic       panelVddEn, lvdsEnable, backlightEn, panelReady, syncLost;
    logic [2:0] seqState;

    int total = 0;
    int bad = 0;
    bit genOn = 0;
    bit badFirst = 0;

    lvds_panel_sequencer #(
        .T_VDD_TO_LVDS(TV), .T_LVDS_TO_BL(TL), .T_BL_TO_LVDS(TB), .T_LVDS_TO_VDD(TD),
        .T_VDD_OFF_MIN(TC), .T_FRAME_MAX(TF), .LOCK_FRAMES(LF)
    ) dut (
        .pixelClock(pixelClock), .resetN(resetN), .panelOnReq(panelOnReq),
        .vsync(vsync), .de(de), .panelVddEn(panelVddEn), .lvdsEnable(lvdsEnable),
        .backlightEn(backlightEn), .panelReady(panelReady), .syncLost(syncLost),
        .seqState(seqState)
    );

    always #5 pixelClock = ~pixelClock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // 60-cycle frames: de on positions 5..44, vsync high on 55..56.
    initial begin
        int pos, frameIdx;
        vsync = 1'b0;
        de = 1'b0;
        pos = 0;
        frameIdx = 0;
        forever begin
            @(negedge pixelClock);
            if (!genOn) begin
                pos = 0;
                frameIdx = 0;
                vsync = 1'b0;
                de = 1'b0;
            end else begin
                de = (pos >= 5 && pos < 45) && !(badFirst && frameIdx == 0);
                vsync = (pos == 55 || pos == 56);
                if (pos == 59) begin
                    pos = 0;
                    frameIdx++;
                end else pos++;
            end
        end
    end

    // Reference model: state plus entry/restart timestamps; expiries are elapsed-time tests.
    int cyc = 0, mState = 0, mEntry = 0, mRef = 0, lastDe = -1, lastEdge = -1;
    bit mPrevV = 0, mLost = 0;
    bit frames[$];

    function automatic int dwell(input int s);
        int t;
        case (s)
            1: t = TV;
            2: t = TL;
            5: t = TB;
            6: t = TD;
            7: t = TC;
            default: t = 1;
        endcase
        return (t < 1) ? 1 : t;
    endfunction

    always @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            mState = 0;
            mLost = 0;
            mPrevV = 0;
            frames.delete();
            lastDe = cyc - 1;
            lastEdge = cyc - 1;
            mEntry = cyc;
            mRef = cyc;
        end else begin : step
            bit vEdge, expd, watch, tmo, lock;
            int nxt;
            vEdge = vsync && !mPrevV;
            expd  = (cyc - mEntry) >= dwell(mState);
            watch = (mState == 3) || (mState == 4);
            tmo   = watch && !vEdge && (cyc - mRef >= TF);
            lock  = 0;
            if (mState == 3 && vEdge) begin
                frames.push_back(lastDe > lastEdge);
                if (frames.size() >= LF) begin
                    lock = 1;
                    for (int i = frames.size() - LF; i < frames.size(); i++)
                        if (!frames[i]) lock = 0;
                end
            end
            nxt = mState;
            case (mState)
                0: if (panelOnReq) nxt = 1;
                1: if (!panelOnReq) nxt = 7; else if (expd) nxt = 2;
                2: if (!panelOnReq) nxt = 6; else if (expd) nxt = 3;
                3: if (!panelOnReq) nxt = 6; else if (lock) nxt = 4;
                4: if (!panelOnReq || tmo) nxt = 5;
                5: if (expd) nxt = panelOnReq ? 3 : 6;
                6: if (expd) nxt = 7;
                default: if (expd) nxt = 0;
            endcase
            if (tmo) mLost = 1;
            else if ((nxt == 4 && mState != 4) || nxt == 0) mLost = 0;
            if (tmo || nxt != 3) frames.delete();
            if (vEdge || tmo || (nxt == 3 && mState != 3)) mRef = cyc;
            if (vEdge) lastEdge = cyc;
            if (de) lastDe = cyc;
            if (nxt != mState) mEntry = cyc;
            mState = nxt;
            mPrevV = vsync;
            cyc++;
        end
    end

    initial begin
        logic [7:0] vddMap, lvdsMap, onMap;
        logic [2:0] s;
        vddMap  = 8'b0111_1110;
        lvdsMap = 8'b0011_1100;
        onMap   = 8'b0001_0000;
        @(posedge pixelClock);
        forever begin
            @(negedge pixelClock);
            s = 3'(mState);
            check("cycle_model",
                  {24'd0, seqState, panelVddEn, lvdsEnable, backlightEn, panelReady, syncLost},
                  {24'd0, s, vddMap[s], lvdsMap[s], onMap[s], onMap[s], mLost});
        end
    end

    task automatic waitState(input logic [2:0] s, input int limit, output int n);
        n = 0;
        while (seqState !== s && n < limit) begin
            @(negedge pixelClock);
            n++;
        end
        check("wait_state", seqState, s);
    endtask

    initial begin
        int n, edges;
        logic prevV;
        bit lvdsSeen;
        repeat (3) @(negedge pixelClock);
        check("reset_outs", {seqState, panelVddEn, lvdsEnable, backlightEn, panelReady, syncLost}, 0);
        resetN = 1'b1;

        // power-up
        @(negedge pixelClock);
        panelOnReq = 1'b1;
        genOn = 1;
        @(negedge pixelClock);
        check("vdd_up_state", seqState, 1);
        check("vdd_at_plus1", panelVddEn, 1);
        check("lvds_off_in_vdd_up", lvdsEnable, 0);
        waitState(2, 30, n);
        check("vdd_to_lvds", n, TV);
        check("lvds_on", lvdsEnable, 1);
        waitState(3, 40, n);
        check("lvds_to_lock", n, TL);
        waitState(4, 300, n);
        check("bl_on", backlightEn, 1);
        check("ready_on", panelReady, 1);

        // sync loss in ON
        genOn = 0;
        waitState(5, 200, n);
        check("wdog_cycles", n, TF);
        check("sync_lost_set", syncLost, 1);
        check("bl_off_on_loss", backlightEn, 0);
        waitState(3, 20, n);
        check("bl_down_dwell", n, TB);
        check("sync_lost_held", syncLost, 1);
        genOn = 1;
        waitState(4, 300, n);
        check("sync_lost_clr", syncLost, 0);

        // invalid first frame in WAIT_LOCK
        genOn = 0;
        waitState(5, 200, n);
        waitState(3, 20, n);
        badFirst = 1;
        genOn = 1;
        edges = 0;
        prevV = 1'b0;
        n = 0;
        while (seqState != 4 && n < 400) begin
            @(negedge pixelClock);
            #1;
            n++;
            if (seqState == 3 && vsync && !prevV) edges++;
            prevV = vsync;
        end
        badFirst = 0;
        check("lock_edges", edges, 3);
        check("relock_state", seqState, 4);

        // power-down
        panelOnReq = 1'b0;
        @(negedge pixelClock);
        check("pd_bl_down", seqState, 5);
        check("pd_bl_off", backlightEn, 0);
        waitState(6, 20, n);
        check("pd_bl_to_lvds", n, TB);
        check("pd_lvds_off", lvdsEnable, 0);
        check("pd_vdd_held", panelVddEn, 1);
        waitState(7, 20, n);
        check("pd_lvds_to_vdd", n, TD);
        check("pd_vdd_off", panelVddEn, 0);
        waitState(0, 100, n);
        check("pd_cool", n, TC);
        genOn = 0;

        // abort in VDD_UP, request during VDD_COOL ignored
        panelOnReq = 1'b1;
        @(negedge pixelClock);
        check("abort_vdd_up", seqState, 1);
        lvdsSeen = 0;
        repeat (4) begin
            @(negedge pixelClock);
            lvdsSeen |= lvdsEnable;
        end
        panelOnReq = 1'b0;
        @(negedge pixelClock);
        check("abort_to_cool", seqState, 7);
        check("abort_vdd_off", panelVddEn, 0);
        n = 0;
        while (seqState != 0 && n < 100) begin
            @(negedge pixelClock);
            n++;
            lvdsSeen |= lvdsEnable;
            if (n == 10) panelOnReq = 1'b1;
        end
        check("abort_cool_dwell", n, TC);
        check("abort_no_lvds", lvdsSeen, 0);
        @(negedge pixelClock);
        check("restart_after_cool", seqState, 1);
        genOn = 1;
        waitState(4, 300, n);
        check("restart_on", panelReady, 1);

        // asynchronous reset while ON
        @(negedge pixelClock);
        #2 resetN = 1'b0;
        #1 check("async_reset", {seqState, panelVddEn, lvdsEnable, backlightEn, panelReady, syncLost}, 0);
        panelOnReq = 1'b0;
        genOn = 0;
        repeat (3) @(negedge pixelClock);
        resetN = 1'b1;
        repeat (5) @(negedge pixelClock);
        check("stay_off", seqState, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lvds_panel_sequencer.md
LVDS_PANEL_SEQUENCER -- requirements
Module: lvds_panel_sequencer

Interface
REQ-001 SHALL have parameter T_VDD_TO_LVDS, default 500000: cycles from panel VDD on to LVDS enable.
REQ-002 SHALL have parameter T_LVDS_TO_BL, default 2500000: cycles from LVDS enable to start of lock check.
REQ-003 SHALL have parameter T_BL_TO_LVDS, default 2500000: cycles from backlight off to LVDS disable.
REQ-004 SHALL have parameter T_LVDS_TO_VDD, default 500000: cycles from LVDS disable to VDD off.
REQ-005 SHALL have parameter T_VDD_OFF_MIN, default 12500000: minimum VDD-off dwell before restart.
REQ-006 SHALL have parameter T_FRAME_MAX, default 1000000: vsync watchdog limit in cycles.
REQ-007 SHALL have parameter LOCK_FRAMES, default 3: valid frames required for lock (range 1..15).
REQ-008 SHALL have port pixelClock, input, 1: single clock; all logic on its rising edge.
REQ-009 SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port panelOnReq, input, 1: level request, 1 = panel on.
REQ-011 SHALL have port vsync, input, 1: frame sync, synchronous to pixelClock, active high.
REQ-012 SHALL have port de, input, 1: data enable, synchronous to pixelClock.
REQ-013 SHALL have port panelVddEn, output, 1: panel supply enable.
REQ-014 SHALL have port lvdsEnable, output, 1: gates the LVDS serializer.
REQ-015 SHALL have port backlightEn, output, 1: backlight enable.
REQ-016 SHALL have port panelReady, output, 1: high only in ON.
REQ-017 SHALL have port syncLost, output, 1: sticky vsync-timeout flag.
REQ-018 SHALL have port seqState, output, 3: current state encoding.

Function
REQ-019 SHALL implement states OFF=0, VDD_UP=1, LVDS_UP=2, WAIT_LOCK=3, ON=4, BL_DOWN=5, LVDS_DOWN=6, VDD_COOL=7.
REQ-020 SHALL register all outputs, changing on the same edge as the seqState transition.
REQ-021 SHALL drive panelVddEn=1 in states 1-6; lvdsEnable=1 in states 2-5; backlightEn=1 and panelReady=1 in state 4 only.
REQ-022 SHALL dwell exactly N cycles in each timed state (VDD_UP, LVDS_UP, BL_DOWN, LVDS_DOWN, VDD_COOL) for parameter value N; N=0 treated as 1.
REQ-023 SHALL use a single down-counter timer of width ceil(log2(max parameter+1)), reloaded on every state entry.
REQ-024 SHALL go OFF->VDD_UP on the cycle after panelOnReq=1 is sampled in OFF.
REQ-025 SHALL go VDD_UP->LVDS_UP on expiry; if panelOnReq=0 during VDD_UP: go to VDD_COOL next cycle.
REQ-026 SHALL go LVDS_UP->WAIT_LOCK on expiry; if panelOnReq=0: go to LVDS_DOWN next cycle.
REQ-027 SHALL detect a vsync rising edge as vsync=1 with its previous-cycle value 0.
REQ-028 SHALL count a frame as valid when its vsync edge is preceded by at least one de=1 cycle since the prior edge.
REQ-029 SHALL go WAIT_LOCK->ON after LOCK_FRAMES consecutive valid frames; an invalid frame resets the count to 0.
REQ-030 SHALL treat T_FRAME_MAX cycles without a vsync edge in WAIT_LOCK or ON as timeout: set syncLost, clear the frame count.
REQ-031 SHALL go ON->BL_DOWN on timeout or panelOnReq=0; WAIT_LOCK->LVDS_DOWN on panelOnReq=0.
REQ-032 SHALL, on BL_DOWN expiry, go to WAIT_LOCK if panelOnReq=1, else to LVDS_DOWN.
REQ-033 SHALL go LVDS_DOWN->VDD_COOL->OFF on expiry, ignoring panelOnReq in both states.
REQ-034 SHALL clear syncLost on entry to ON or while in OFF; a timeout and ON entry in the same cycle leaves syncLost=1.
REQ-035 SHALL restart the watchdog on every vsync edge and on entry to WAIT_LOCK.

Reset
REQ-036 SHALL, while resetN=0, force state OFF, timer 0, frame count 0, all outputs 0, seqState=0, vsync history 0.
REQ-037 SHALL, on reset mid-sequence, drop all enables immediately with no power-down ordering.

Verification (T_VDD_TO_LVDS=10, T_LVDS_TO_BL=20, T_BL_TO_LVDS=5, T_LVDS_TO_VDD=8, T_VDD_OFF_MIN=50, T_FRAME_MAX=100, LOCK_FRAMES=2)
REQ-038 SHALL cover power-up: panelOnReq=1 with frames of 60 cycles, de active -> panelVddEn at +1, lvdsEnable 10 cycles later, WAIT_LOCK 20 cycles later, ON after 2nd valid vsync edge.
REQ-039 SHALL cover power-down from ON: panelOnReq=0 -> backlightEn=0 next cycle, lvdsEnable=0 5 cycles later, panelVddEn=0 8 cycles later, OFF 50 cycles later.
REQ-040 SHALL cover sync loss: vsync held low 100 cycles in ON -> syncLost=1, BL_DOWN, then WAIT_LOCK; two valid frames -> ON, syncLost=0.
REQ-041 SHALL cover invalid frame: de held 0 for one frame in WAIT_LOCK -> count resets; ON only after 2 more valid frames.
REQ-042 SHALL cover abort: panelOnReq drops in VDD_UP -> VDD_COOL next cycle, lvdsEnable never asserted; request during VDD_COOL is ignored until OFF.
REQ-043 SHALL cover reset: resetN=0 in ON -> all outputs 0 asynchronously, seqState=0.
